// File: rtl/tbox_nk.sv
// tbox_nk: N x N, K-in-a-row board controller with a fixed four-cycle win scan.
// Defining TBOX_NK_UNDO_EN adds the undo port and a one-level undo of the last move.
module tbox_nk #(
  parameter int N = 3,
  parameter int K = 3,
  localparam int W = $clog2(N + 1),
  localparam int C = $clog2(N * N + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           set,
`ifdef TBOX_NK_UNDO_EN
  input  logic           undo,
`endif
  input  logic [W-1:0]   row,
  input  logic [W-1:0]   col,
  output logic [N*N-1:0] valid,
  output logic [N*N-1:0] symbol,
  output logic [1:0]     game_state,
  output logic           turn,
  output logic           busy,
  output logic           err,
  output logic [C-1:0]   move_count
);

  localparam int NN = N * N;
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam int RW = $clog2(K) + 1;
  localparam logic [C-1:0] CELLS_FULL = C'(NN);

  localparam logic [1:0] GS_ON   = 2'b00;
  localparam logic [1:0] GS_XWIN = 2'b01;
  localparam logic [1:0] GS_OWIN = 2'b10;
  localparam logic [1:0] GS_DRAW = 2'b11;

  typedef enum logic [2:0] {IDLE, SCAN0, SCAN1, SCAN2, SCAN3} state_t;

  state_t        state_q, state_d;
  logic          set_q;
  logic [NN-1:0] valid_q, valid_d;
  logic [NN-1:0] symbol_q, symbol_d;
  logic [1:0]    gs_q, gs_d;
  logic          turn_q, turn_d;
  logic          err_q, err_d;
  logic [C-1:0]  count_q, count_d;
  logic [W-1:0]  last_r_q, last_r_d;
  logic [W-1:0]  last_c_q, last_c_d;
  logic          last_sym_q, last_sym_d;
  logic          win_q, win_d;
`ifdef TBOX_NK_UNDO_EN
  logic          undo_q;
  logic          hist_q, hist_d;
  logic          undo_req;
`endif

  logic          set_req;
  logic          any_req;
  logic          coord_ok;
  logic [IW-1:0] move_idx;
  logic [IW-1:0] last_idx;
  int            dr, dc;
  logic [RW-1:0] run_fwd, run_bwd;
  logic          line_hit;

  function automatic logic [IW-1:0] cell_idx(input logic [W-1:0] r0, input logic [W-1:0] c0);
    return IW'(int'(r0) * N + int'(c0));
  endfunction

  // Consecutive cells owned by sym, walking from (r0,c0) by (sdr,sdc), stopping at the edge.
  function automatic logic [RW-1:0] run_len(input int r0, input int c0, input int sdr,
                                            input int sdc, input logic sym,
                                            input logic [NN-1:0] v, input logic [NN-1:0] s);
    logic [RW-1:0] n;
    logic          alive;
    int            r;
    int            c;
    n     = '0;
    alive = 1'b1;
    for (int i = 1; i < K; i++) begin
      r = r0 + i * sdr;
      c = c0 + i * sdc;
      if (alive && r >= 0 && r < N && c >= 0 && c < N) begin
        if (v[IW'(r * N + c)] && (s[IW'(r * N + c)] == sym)) n = n + RW'(1);
        else alive = 1'b0;
      end else begin
        alive = 1'b0;
      end
    end
    return n;
  endfunction

  always_comb begin
    dr = 0;
    dc = 1;
    case (state_q)
      SCAN1:   begin dr = 1; dc = 0;  end
      SCAN2:   begin dr = 1; dc = 1;  end
      SCAN3:   begin dr = 1; dc = -1; end
      default: begin dr = 0; dc = 1;  end
    endcase
    run_fwd  = run_len(int'(last_r_q), int'(last_c_q), dr, dc, last_sym_q, valid_q, symbol_q);
    run_bwd  = run_len(int'(last_r_q), int'(last_c_q), -dr, -dc, last_sym_q, valid_q, symbol_q);
    line_hit = (1 + int'(run_fwd) + int'(run_bwd)) >= K;
  end

  // Bounds are checked before the index is formed so bad coordinates never alias a cell.
  always_comb begin
    set_req  = set & ~set_q;
    coord_ok = (row != '0) && (row <= W'(N)) && (col != '0) && (col <= W'(N));
    move_idx = coord_ok ? cell_idx(row - W'(1), col - W'(1)) : '0;
    last_idx = cell_idx(last_r_q, last_c_q);
`ifdef TBOX_NK_UNDO_EN
    undo_req = undo & ~undo_q;
    any_req  = set_req | undo_req;
`else
    any_req  = set_req;
`endif
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    symbol_d   = symbol_q;
    gs_d       = gs_q;
    turn_d     = turn_q;
    count_d    = count_q;
    last_r_d   = last_r_q;
    last_c_d   = last_c_q;
    last_sym_d = last_sym_q;
    win_d      = win_q;
    err_d      = 1'b0;
`ifdef TBOX_NK_UNDO_EN
    hist_d     = hist_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef TBOX_NK_UNDO_EN
        if (set_req && undo_req) begin
          err_d = 1'b1;
        end else if (undo_req) begin
          if (hist_q && (count_q != '0)) begin
            valid_d[last_idx]  = 1'b0;
            symbol_d[last_idx] = 1'b0;
            count_d            = count_q - C'(1);
            turn_d             = ~turn_q;
            gs_d               = GS_ON;
            hist_d             = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else
`endif
        if (set_req) begin
          if ((gs_q == GS_ON) && coord_ok && !valid_q[move_idx]) begin
            valid_d[move_idx]  = 1'b1;
            symbol_d[move_idx] = turn_q;
            turn_d             = ~turn_q;
            count_d            = count_q + C'(1);
            last_r_d           = row - W'(1);
            last_c_d           = col - W'(1);
            last_sym_d         = turn_q;
            state_d            = SCAN0;
`ifdef TBOX_NK_UNDO_EN
            hist_d             = 1'b1;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SCAN0: begin
        win_d   = win_q | line_hit;
        err_d   = any_req;
        state_d = SCAN1;
      end
      SCAN1: begin
        win_d   = win_q | line_hit;
        err_d   = any_req;
        state_d = SCAN2;
      end
      SCAN2: begin
        win_d   = win_q | line_hit;
        err_d   = any_req;
        state_d = SCAN3;
      end
      SCAN3: begin
        if (win_q || line_hit) gs_d = last_sym_q ? GS_XWIN : GS_OWIN;
        else if (count_q == CELLS_FULL) gs_d = GS_DRAW;
        win_d   = 1'b0;
        err_d   = any_req;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      set_q      <= 1'b0;
      valid_q    <= '0;
      symbol_q   <= '0;
      gs_q       <= GS_ON;
      turn_q     <= 1'b1;
      err_q      <= 1'b0;
      count_q    <= '0;
      last_r_q   <= '0;
      last_c_q   <= '0;
      last_sym_q <= 1'b0;
      win_q      <= 1'b0;
`ifdef TBOX_NK_UNDO_EN
      undo_q     <= 1'b0;
      hist_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      set_q      <= set;
      valid_q    <= valid_d;
      symbol_q   <= symbol_d;
      gs_q       <= gs_d;
      turn_q     <= turn_d;
      err_q      <= err_d;
      count_q    <= count_d;
      last_r_q   <= last_r_d;
      last_c_q   <= last_c_d;
      last_sym_q <= last_sym_d;
      win_q      <= win_d;
`ifdef TBOX_NK_UNDO_EN
      undo_q     <= undo;
      hist_q     <= hist_d;
`endif
    end
  end

  assign valid      = valid_q;
  assign symbol     = symbol_q;
  assign game_state = gs_q;
  assign turn       = turn_q;
  assign busy       = (state_q != IDLE);
  assign err        = err_q;
  assign move_count = count_q;

endmodule

// File: tb/tb_tbox_nk.sv
// Bench for tbox_nk: directed and random games on a 3x3/K=3 and a 5x5/K=4 board,
// checked against a whole-board line-search model.
module tb_tbox_nk;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        set_a, set_b;
  logic [1:0]  row_a, col_a;
  logic [2:0]  row_b, col_b;
  logic [8:0]  valid_a, symbol_a;
  logic [1:0]  gs_a, gs_b;
  logic        turn_a, busy_a, err_a, turn_b, busy_b, err_b;
  logic [3:0]  cnt_a;
  logic [24:0] valid_b, symbol_b;
  logic [4:0]  cnt_b;
`ifdef TBOX_NK_UNDO_EN
  logic        undo_a, undo_b;
`endif

  int checks = 0;
  int failures = 0;
  int mw, mn, mk, mturn, mcount, mgs, mlr, mlc, mhist;
  int board[15][15];
  int owin[12]  = '{1,1, 2,2, 1,3, 1,2, 3,3, 3,2};
  int draw[18]  = '{1,1, 1,2, 1,3, 2,2, 2,1, 2,3, 3,2, 3,1, 3,3};
  int k4[14]    = '{2,2, 1,5, 3,3, 2,5, 4,4, 5,1, 5,5};

  always #5 clk = ~clk;

  tbox_nk #(.N(3), .K(3)) u_a (
    .clk(clk), .reset(reset_n), .set(set_a),
`ifdef TBOX_NK_UNDO_EN
    .undo(undo_a),
`endif
    .row(row_a), .col(col_a), .valid(valid_a), .symbol(symbol_a), .game_state(gs_a),
    .turn(turn_a), .busy(busy_a), .err(err_a), .move_count(cnt_a)
  );

  tbox_nk #(.N(5), .K(4)) u_b (
    .clk(clk), .reset(reset_n), .set(set_b),
`ifdef TBOX_NK_UNDO_EN
    .undo(undo_b),
`endif
    .row(row_b), .col(col_b), .valid(valid_b), .symbol(symbol_b), .game_state(gs_b),
    .turn(turn_b), .busy(busy_b), .err(err_b), .move_count(cnt_b)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] o_valid();
    if (mw == 0) return 256'(valid_a);
    return 256'(valid_b);
  endfunction
  function automatic logic [255:0] o_symbol();
    if (mw == 0) return 256'(symbol_a);
    return 256'(symbol_b);
  endfunction
  function automatic logic [255:0] o_gs();
    if (mw == 0) return 256'(gs_a);
    return 256'(gs_b);
  endfunction
  function automatic logic [255:0] o_turn();
    if (mw == 0) return 256'(turn_a);
    return 256'(turn_b);
  endfunction
  function automatic logic [255:0] o_busy();
    if (mw == 0) return 256'(busy_a);
    return 256'(busy_b);
  endfunction
  function automatic logic [255:0] o_err();
    if (mw == 0) return 256'(err_a);
    return 256'(err_b);
  endfunction
  function automatic logic [255:0] o_count();
    if (mw == 0) return 256'(cnt_a);
    return 256'(cnt_b);
  endfunction

  function automatic void model_init(input int w, input int n, input int k);
    mw = w; mn = n; mk = k; mturn = 1; mcount = 0; mgs = 0; mlr = 0; mlc = 0; mhist = 0;
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++) board[r][c] = 0;
  endfunction

  function automatic bit model_legal(input int r, input int c);
    if (mgs != 0) return 1'b0;
    if (r < 1 || r > mn || c < 1 || c > mn) return 1'b0;
    return board[r-1][c-1] == 0;
  endfunction

  // Any K-long line of one player anywhere on the board decides the game.
  function automatic int judge();
    int drs[4] = '{0, 1, 1, 1};
    int dcs[4] = '{1, 0, 1, -1};
    int rr, cc, n;
    for (int p = 1; p <= 2; p++)
      for (int r = 0; r < mn; r++)
        for (int c = 0; c < mn; c++)
          for (int d = 0; d < 4; d++) begin
            n = 0;
            for (int i = 0; i < mk; i++) begin
              rr = r + i * drs[d];
              cc = c + i * dcs[d];
              if (rr >= 0 && rr < mn && cc >= 0 && cc < mn)
                if (board[rr][cc] == p) n++;
            end
            if (n == mk) return p;
          end
    if (mcount == mn * mn) return 3;
    return 0;
  endfunction

  function automatic void model_place(input int r, input int c);
    board[r-1][c-1] = (mturn == 1) ? 1 : 2;
    mturn  = 1 - mturn;
    mcount = mcount + 1;
    mlr = r; mlc = c; mhist = 1;
    mgs = judge();
  endfunction

  function automatic logic [255:0] exp_valid();
    logic [255:0] v;
    v = '0;
    for (int r = 0; r < mn; r++)
      for (int c = 0; c < mn; c++)
        if (board[r][c] != 0) v[r*mn+c] = 1'b1;
    return v;
  endfunction

  function automatic logic [255:0] exp_symbol();
    logic [255:0] v;
    v = '0;
    for (int r = 0; r < mn; r++)
      for (int c = 0; c < mn; c++)
        if (board[r][c] == 1) v[r*mn+c] = 1'b1;
    return v;
  endfunction

  task automatic drive(input logic s, input int r, input int c);
    if (mw == 0) begin set_a = s; row_a = 2'(r); col_a = 2'(c); end
    else begin set_b = s; row_b = 3'(r); col_b = 3'(c); end
  endtask

  task automatic do_reset();
    set_a = 1'b0; set_b = 1'b0;
    row_a = '0; col_a = '0; row_b = '0; col_b = '0;
`ifdef TBOX_NK_UNDO_EN
    undo_a = 1'b0; undo_b = 1'b0;
`endif
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic check_board(input string tag);
    chk({tag, "_valid"}, o_valid(), exp_valid());
    chk({tag, "_symbol"}, o_symbol(), exp_symbol());
    chk({tag, "_turn"}, o_turn(), 256'(mturn));
    chk({tag, "_count"}, o_count(), 256'(mcount));
  endtask

  // Holds set for two cycles; coordinates are scrambled on the second cycle.
  task automatic move(input int r, input int c);
    bit acc;
    acc = model_legal(r, c);
    @(negedge clk); drive(1'b1, r, c);
    @(posedge clk); #1;
    chk("req_err", o_err(), 256'(!acc));
    if (acc) model_place(r, c);
    check_board("req");
    if (acc) chk("req_busy", o_busy(), 256'(1));
    @(negedge clk); drive(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    @(posedge clk); #1;
    chk("hold_err", o_err(), 256'(0));
    @(negedge clk); drive(1'b0, r, c);
    if (acc) begin
      @(posedge clk);
      @(posedge clk); #1;
      chk("scan_busy", o_busy(), 256'(1));
      @(posedge clk); #1;
      chk("done_busy", o_busy(), 256'(0));
      chk("done_state", o_gs(), 256'(mgs));
      check_board("done");
    end else begin
      chk("rej_state", o_gs(), 256'(mgs));
    end
  endtask

  task automatic busy_req(input int r1, input int c1, input int r2, input int c2);
    @(negedge clk); drive(1'b1, r1, c1);
    @(posedge clk); #1;
    model_place(r1, c1);
    chk("busy_first", o_busy(), 256'(1));
    @(negedge clk); drive(1'b0, r1, c1);
    @(posedge clk);
    @(negedge clk); drive(1'b1, r2, c2);
    @(posedge clk); #1;
    chk("busy_req_err", o_err(), 256'(1));
    check_board("busy_req");
    @(negedge clk); drive(1'b0, r2, c2);
    @(posedge clk);
    @(posedge clk); #1;
    chk("busy_end", o_busy(), 256'(0));
    chk("busy_state", o_gs(), 256'(mgs));
    check_board("busy_end");
  endtask

`ifdef TBOX_NK_UNDO_EN
  task automatic do_undo(input logic with_set);
    bit ok;
    ok = (mcount > 0) && (mhist == 1) && !with_set;
    @(negedge clk);
    if (mw == 0) undo_a = 1'b1; else undo_b = 1'b1;
    if (with_set) drive(1'b1, 1, 1);
    @(posedge clk); #1;
    chk("undo_err", o_err(), 256'(!ok));
    if (ok) begin
      board[mlr-1][mlc-1] = 0;
      mcount = mcount - 1; mturn = 1 - mturn; mgs = 0; mhist = 0;
    end
    check_board("undo");
    chk("undo_gs", o_gs(), 256'(mgs));
    @(negedge clk);
    undo_a = 1'b0; undo_b = 1'b0;
    drive(1'b0, 1, 1);
  endtask
`endif

  initial begin
    reset_n = 1'b1;
    set_a = 1'b0; set_b = 1'b0;
    row_a = '0; col_a = '0; row_b = '0; col_b = '0;
`ifdef TBOX_NK_UNDO_EN
    undo_a = 1'b0; undo_b = 1'b0;
`endif
    #1 reset_n = 1'b0;
    do_reset();

    // Reset values
    model_init(1, 5, 4);
    chk("rst_b_valid", o_valid(), 256'(0));
    chk("rst_b_turn", o_turn(), 256'(1));
    model_init(0, 3, 3);
    chk("rst_valid", o_valid(), 256'(0));
    chk("rst_symbol", o_symbol(), 256'(0));
    chk("rst_state", o_gs(), 256'(0));
    chk("rst_turn", o_turn(), 256'(1));
    chk("rst_busy", o_busy(), 256'(0));
    chk("rst_err", o_err(), 256'(0));
    chk("rst_count", o_count(), 256'(0));

    // O wins, with out-of-range, occupied and busy rejections along the way
    for (int i = 0; i < 6; i++) begin
      if (i == 2) busy_req(owin[2*i], owin[2*i+1], 3, 1);
      else move(owin[2*i], owin[2*i+1]);
      if (i == 1) begin
        move(0, 2);
        move(4, 1);
        move(2, 2);
      end
    end
    chk("owin_state", o_gs(), 256'(2));
    move(2, 1);
`ifdef TBOX_NK_UNDO_EN
    do_undo(1'b0);
    chk("undo_state", o_gs(), 256'(0));
    chk("undo_turn", o_turn(), 256'(0));
    chk("undo_count", o_count(), 256'(5));
    do_undo(1'b0);
    move(3, 2);
    do_undo(1'b1);
`endif

    // Draw
    do_reset();
    model_init(0, 3, 3);
    for (int i = 0; i < 9; i++) move(draw[2*i], draw[2*i+1]);
    chk("draw_state", o_gs(), 256'(3));
    chk("draw_count", o_count(), 256'(9));

    // N=5 K=4 diagonal
    do_reset();
    model_init(1, 5, 4);
    for (int i = 0; i < 5; i++) move(k4[2*i], k4[2*i+1]);
    chk("k4_three_state", o_gs(), 256'(0));
    move(6, 1);
    move(0, 3);
    move(k4[10], k4[11]);
    move(k4[12], k4[13]);
    chk("k4_win_state", o_gs(), 256'(1));

    // Reset in the middle of a scan
    do_reset();
    model_init(0, 3, 3);
    @(negedge clk); drive(1'b1, 2, 2);
    @(posedge clk);
    @(negedge clk); drive(1'b0, 2, 2);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", o_valid(), 256'(0));
    chk("midrst_busy", o_busy(), 256'(0));
    chk("midrst_turn", o_turn(), 256'(1));
    chk("midrst_count", o_count(), 256'(0));
    @(negedge clk); reset_n = 1'b1;

    // Random games on both boards
    for (int g = 0; g < 4; g++) begin
      do_reset();
      if (g % 2 == 0) model_init(0, 3, 3);
      else model_init(1, 5, 4);
      for (int m = 0; m < 60 && mgs == 0; m++)
        move(int'($urandom_range(0, mn + 1)), int'($urandom_range(0, mn + 1)));
      move(int'($urandom_range(1, mn)), int'($urandom_range(1, mn)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
